// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers. Results are computed at the accepting
// edge and committed to HI/LO after a fixed occupancy of MULT_CYCLES or DIV_CYCLES.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_result;
  logic        r_commit;

  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic [31:0] w_divisor;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_mag_q;
  logic [31:0] w_mag_r;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic        w_div0;
  md_op_t      w_op;

  assign w_op = md_op_t'(md_op);

  // Sign-extended operands: the low 64 bits of the unsigned product are the signed product.
  assign w_smul = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign w_umul = {32'b0, src_a} * {32'b0, src_b};

  // Divide-by-zero result is discarded; a divisor of 1 keeps the datapath defined.
  assign w_div0    = (src_b == '0);
  assign w_divisor = w_div0 ? 32'd1 : src_b;

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    w_abs_a = src_a[31] ? (~src_a + 32'd1) : src_a;
    w_abs_b = w_divisor[31] ? (~w_divisor + 32'd1) : w_divisor;
    w_mag_q = w_abs_a / w_abs_b;
    w_mag_r = w_abs_a % w_abs_b;
    w_sq    = (src_a[31] ^ w_divisor[31]) ? (~w_mag_q + 32'd1) : w_mag_q;
    w_sr    = src_a[31] ? (~w_mag_r + 32'd1) : w_mag_r;
    w_uq    = src_a / w_divisor;
    w_ur    = src_a % w_divisor;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_commit <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            case (w_op)
              OP_MULT: begin
                r_result <= w_smul;
                r_commit <= 1'b1;
                r_cnt    <= MULT_LOAD;
                r_state  <= MUL_RUN;
              end
              OP_MULTU: begin
                r_result <= w_umul;
                r_commit <= 1'b1;
                r_cnt    <= MULT_LOAD;
                r_state  <= MUL_RUN;
              end
              OP_DIV: begin
                r_result <= {w_sr, w_sq};
                r_commit <= ~w_div0;
                r_cnt    <= DIV_LOAD;
                r_state  <= DIV_RUN;
              end
              OP_DIVU: begin
                r_result <= {w_ur, w_uq};
                r_commit <= ~w_div0;
                r_cnt    <= DIV_LOAD;
                r_state  <= DIV_RUN;
              end
              OP_MTHI: r_hi <= src_a;
              OP_MTLO: r_lo <= src_a;
              default: ;
            endcase
          end
        end
        MUL_RUN, DIV_RUN: begin
          if (r_cnt == 4'd1) begin
            if (r_commit) begin
              r_hi <= r_result[63:32];
              r_lo <= r_result[31:0];
            end
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign md_out = rd_sel ? r_hi : r_lo;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, mult/multu occupancy in clock cycles (legal range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, div/divu occupancy in clock cycles (legal range 1..15).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on rising edge of clk.
REQ-005 start  input  1  one-cycle request, qualifies md_op for this cycle.
REQ-006 md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
REQ-007 src_a  input  32  operand A (multiplicand, dividend, or mthi/mtlo data).
REQ-008 src_b  input  32  operand B (multiplier or divisor).
REQ-009 rd_sel  input  1  0 selects LO, 1 selects HI onto md_out.
REQ-010 busy  output  1  high while an operation occupies the unit.
REQ-011 md_out  output  32  combinational read of HI or LO per rd_sel.
REQ-012 hi  output  32  current HI register.
REQ-013 lo  output  32  current LO register.

Function
REQ-014 States: IDLE, MUL_RUN, DIV_RUN; down-counter cnt (4 bits); busy SHALL equal (state != IDLE).
REQ-015 In IDLE with start=1 and md_op in {1,2}: latch product into 64-bit result register, load cnt=MULT_CYCLES, go MUL_RUN at that edge.
REQ-016 In IDLE with start=1 and md_op in {3,4}: latch quotient/remainder into result register, load cnt=DIV_CYCLES, go DIV_RUN at that edge.
REQ-017 In MUL_RUN/DIV_RUN each edge decrements cnt; on the edge where cnt==1, HI/LO SHALL be written from the result register and state returns to IDLE.
REQ-018 Latency: start sampled at edge k -> busy=1 for exactly N cycles following edge k; new HI/LO visible after edge k+N; busy=0 after edge k+N (N = MULT_CYCLES or DIV_CYCLES).
REQ-019 mult: {HI,LO} = signed(src_a) * signed(src_b), full 64 bits; multu: unsigned 64-bit product.
REQ-020 div: LO = quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-021 div with src_a=0x80000000, src_b=0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-022 div/divu with src_b=0: unit SHALL still be busy for DIV_CYCLES, then HI and LO SHALL remain unchanged.
REQ-023 mthi/mtlo with start=1 in IDLE: HI (resp. LO) = src_a at that edge, busy stays 0, single-cycle.
REQ-024 start=1 while busy: request SHALL be ignored entirely (no state, counter, HI, LO change); upstream stall logic is responsible for holding it.
REQ-025 start=1 with md_op 0 or 7: no effect.
REQ-026 md_out SHALL reflect HI/LO written on the previous edge (no same-cycle bypass of an mthi/mtlo).
REQ-027 Operands SHALL be captured only at the accepting edge; src_a/src_b changes during busy have no effect.

Reset
REQ-028 reset=0 at a rising edge SHALL set state=IDLE, cnt=0, busy=0, HI=0, LO=0, result register=0.
REQ-029 Reset mid-operation SHALL abort it; no HI/LO write from the aborted operation ever occurs.
REQ-030 reset=0 together with start=1 at the same edge: reset wins, request discarded.

Verification
REQ-031 Reset, then mult src_a=0xFFFFFFFE, src_b=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 multu src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 div src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu same operands -> LO=0x7FFFFFFC, HI=0x00000001.
REQ-034 mthi 0x12345678, mtlo 0x9ABCDEF0 -> next cycle md_out=0x12345678 with rd_sel=1, 0x9ABCDEF0 with rd_sel=0; divu by 0 then leaves both unchanged after 10 busy cycles.
REQ-035 mult started, mtlo 0x55 issued during busy -> ignored, LO = product after completion; second mult during busy ignored.
REQ-036 div started, reset=0 asserted at busy cycle 4 -> busy=0, HI=LO=0 next cycle, no later write.
